mem_port_arbiter: RTL and testbench

//  Shares one SRAM-like memory port (req/addr_ok/data_ok) between the IF-stage

---
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and data access.
// Round-robin grant on contention, one outstanding transaction at a time.
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            inst_req,
  input  logic [AW-1:0]   inst_addr,
  output logic            inst_addr_ok,
  output logic            inst_data_ok,
  output logic [DW-1:0]   inst_rdata,
  input  logic            data_req,
  input  logic            data_wr,
  input  logic [DW/8-1:0] data_wstrb,
  input  logic [AW-1:0]   data_addr,
  input  logic [DW-1:0]   data_wdata,
  output logic            data_addr_ok,
  output logic            data_data_ok,
  output logic [DW-1:0]   data_rdata,
  output logic            mem_req,
  output logic            mem_wr,
  output logic [DW/8-1:0] mem_wstrb,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_addr_ok,
  input  logic            mem_data_ok,
  input  logic [DW-1:0]   mem_rdata,
  output logic [1:0]      dbg_state
);

  // Handshake: mem_req is held in ADDR until mem_addr_ok; the owner's addr_ok
  // and data_ok are single-cycle pulses coinciding with mem_addr_ok / mem_data_ok.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              wr_q, wr_d;
  logic [DW/8-1:0]   wstrb_q, wstrb_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic              grant_data;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      owner_q <= OWN_INST;
      last_q  <= OWN_INST;
      wr_q    <= 1'b0;
      wstrb_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      wstrb_q <= wstrb_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    wr_d       = wr_q;
    wstrb_d    = wstrb_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    grant_data = 1'b0;
    case (state_q)
      IDLE: begin
        if (inst_req || data_req) begin
          // On contention the requester that did not win last time goes first.
          grant_data = data_req && (!inst_req || (last_q == OWN_INST));
          owner_d    = grant_data ? OWN_DATA : OWN_INST;
          last_d     = grant_data ? OWN_DATA : OWN_INST;
          state_d    = ADDR;
          if (grant_data) begin
            wr_d    = data_wr;
            wstrb_d = data_wr ? data_wstrb : '0;
            addr_d  = data_addr;
            wdata_d = data_wdata;
          end else begin
            wr_d    = 1'b0;
            wstrb_d = '0;
            addr_d  = inst_addr;
            wdata_d = '0;
          end
        end
      end
      ADDR: begin
        if (mem_addr_ok) state_d = DATA;
      end
      DATA: begin
        if (mem_data_ok) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_req   = (state_q == ADDR);
  assign mem_wr    = wr_q;
  assign mem_wstrb = wstrb_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign inst_addr_ok = mem_req && mem_addr_ok && (owner_q == OWN_INST);
  assign data_addr_ok = mem_req && mem_addr_ok && (owner_q == OWN_DATA);
  assign inst_data_ok = (state_q == DATA) && mem_data_ok && (owner_q == OWN_INST);
  assign data_data_ok = (state_q == DATA) && mem_data_ok && (owner_q == OWN_DATA);

  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed transactions, expected grants and
// responses queued up front and checked by an independent monitor.
module tb_mem_port_arbiter;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  // Grant record: {is_data, wr, wstrb, addr, wdata}; response record: {is_data, rdata}
  logic [69:0] exp_a_q[$];
  logic [32:0] exp_d_q[$];
  logic [69:0] mon_a;
  logic [32:0] mon_d;
  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [69:0] grant_rec(input logic d, input logic wr, input logic [3:0] st,
                                            input logic [31:0] a, input logic [31:0] wd);
    return {d, wr, st, a, wd};
  endfunction

  always @(negedge clk) begin
    if (inst_addr_ok || data_addr_ok) begin
      chk("addr_ok_both", {69'd0, inst_addr_ok & data_addr_ok}, 70'd0);
      if (exp_a_q.size() == 0) begin
        chk("addr_ok_unexpected", {68'd0, inst_addr_ok, data_addr_ok}, 70'd0);
      end else begin
        mon_a = exp_a_q.pop_front();
        chk("grant", {data_addr_ok, mem_wr, mem_wstrb, mem_addr, mem_wdata}, mon_a);
      end
    end
    if (inst_data_ok || data_data_ok) begin
      chk("data_ok_both", {69'd0, inst_data_ok & data_data_ok}, 70'd0);
      if (exp_d_q.size() == 0) begin
        chk("data_ok_unexpected", {68'd0, inst_data_ok, data_data_ok}, 70'd0);
      end else begin
        mon_d = exp_d_q.pop_front();
        chk("response", {37'd0, data_data_ok, (data_data_ok ? data_rdata : inst_rdata)},
            {37'd0, mon_d});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic serve_addr(input int a_dly);
    int n = 0;
    while (!mem_req && n < 20) begin
      next_cycle();
      n++;
    end
    if (n == 20) chk("mem_req_timeout", {69'd0, mem_req}, 70'd1);
    repeat (a_dly) next_cycle();
    mem_addr_ok = 1'b1;
    next_cycle();
    mem_addr_ok = 1'b0;
  endtask

  task automatic serve_data(input int d_dly, input logic [31:0] rd);
    repeat (d_dly) next_cycle();
    mem_data_ok = 1'b1;
    mem_rdata   = rd;
    next_cycle();
    mem_data_ok = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    resetn = 1'b0; inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = '0; data_addr = '0; data_wdata = '0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    at_neg();
    chk("reset_outputs", {mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata},
        {1'b0, 1'b0, 4'h0, 32'h0, 32'h0});
    chk("reset_acks", {66'd0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 70'd0);
    chk("reset_state", {68'd0, dbg_state}, 70'd0);
    next_cycle();
    resetn = 1'b1;
    next_cycle();

    // Single fetch with exact cycle timing
    inst_req = 1'b1; inst_addr = 32'h1c000000;
    exp_a_q.push_back(grant_rec(1'b0, 1'b0, 4'h0, 32'h1c000000, 32'h0));
    exp_d_q.push_back({1'b0, 32'h02800000});
    at_neg();
    chk("t1_c0_mem_req", {69'd0, mem_req}, 70'd0);
    next_cycle();
    inst_req = 1'b0;
    at_neg();
    chk("t1_c1_mem_req", {37'd0, mem_req, mem_addr}, {37'd0, 1'b1, 32'h1c000000});
    next_cycle();
    mem_addr_ok = 1'b1;
    at_neg();
    chk("t1_c2_mem_req", {68'd0, mem_req, inst_addr_ok}, {68'd0, 2'b11});
    next_cycle();
    mem_addr_ok = 1'b0;
    at_neg();
    chk("t1_c3_mem_req", {69'd0, mem_req}, 70'd0);
    next_cycle();
    mem_data_ok = 1'b1; mem_rdata = 32'h02800000;
    at_neg();
    chk("t1_c4_data_ok", {37'd0, inst_data_ok, inst_rdata}, {37'd0, 1'b1, 32'h02800000});
    next_cycle();
    mem_data_ok = 1'b0;
    at_neg();
    chk("t1_c5_idle", {68'd0, dbg_state}, 70'd0);
    chk("t1_drained", {38'd0, exp_a_q.size()} + {38'd0, exp_d_q.size()}, 70'd0);

    // Fresh reset, then both requesters held for four transactions: D, I, D, I
    next_cycle();
    resetn = 1'b0;
    next_cycle();
    resetn = 1'b1;
    next_cycle();
    inst_req = 1'b1; inst_addr = 32'h1c000010;
    data_req = 1'b1; data_addr = 32'h00000100; data_wr = 1'b0; data_wdata = '0;
    for (int i = 0; i < 4; i++) begin
      exp_a_q.push_back((i % 2 == 0) ? grant_rec(1'b1, 1'b0, 4'h0, 32'h100, 32'h0)
                                     : grant_rec(1'b0, 1'b0, 4'h0, 32'h1c000010, 32'h0));
      exp_d_q.push_back({(i % 2 == 0), 32'hA0000000 + 32'(i)});
    end
    for (int i = 0; i < 4; i++) begin
      serve_addr(i);
      if (i == 3) begin
        inst_req = 1'b0;
        data_req = 1'b0;
      end
      serve_data(i % 2, 32'hA0000000 + 32'(i));
    end
    at_neg();
    chk("t3_drained", {38'd0, exp_a_q.size()} + {38'd0, exp_d_q.size()}, 70'd0);

    // Store
    next_cycle();
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'b0011;
    data_wdata = 32'hdeadbeef; data_addr = 32'h8;
    exp_a_q.push_back(grant_rec(1'b1, 1'b1, 4'b0011, 32'h8, 32'hdeadbeef));
    exp_d_q.push_back({1'b1, 32'h12345678});
    next_cycle();
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = '0;
    serve_addr(0);
    serve_data(1, 32'h12345678);

    // Slow addr_ok while the requester changes its fields after the grant
    data_req = 1'b1; data_addr = 32'h200; data_wdata = 32'h0;
    exp_a_q.push_back(grant_rec(1'b1, 1'b0, 4'h0, 32'h200, 32'h0));
    exp_d_q.push_back({1'b1, 32'hcafef00d});
    next_cycle();
    data_req = 1'b0; data_addr = 32'h300; data_wr = 1'b1; data_wstrb = 4'hf; data_wdata = 32'h55;
    for (int i = 0; i < 5; i++) begin
      at_neg();
      chk("t5_hold", {36'd0, mem_req, mem_wr, mem_addr}, {36'd0, 1'b1, 1'b0, 32'h200});
      next_cycle();
    end
    serve_addr(0);
    data_wr = 1'b0; data_wstrb = '0;
    serve_data(0, 32'hcafef00d);
    at_neg();
    chk("t5_drained", {38'd0, exp_a_q.size()} + {38'd0, exp_d_q.size()}, 70'd0);

    // Reset while in DATA: transaction dropped, late data_ok ignored
    next_cycle();
    inst_req = 1'b1; inst_addr = 32'h40;
    exp_a_q.push_back(grant_rec(1'b0, 1'b0, 4'h0, 32'h40, 32'h0));
    serve_addr(0);
    inst_req = 1'b0;
    at_neg();
    chk("t6_in_data", {68'd0, dbg_state}, 70'd2);
    next_cycle();
    mem_data_ok = 1'b1; mem_rdata = 32'h77777777;
    resetn = 1'b0;
    #1;
    chk("t6_reset_outputs", {mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata}, 70'd0);
    chk("t6_reset_acks", {64'd0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, dbg_state},
        70'd0);
    next_cycle();
    mem_data_ok = 1'b0;
    next_cycle();
    resetn = 1'b1;
    next_cycle();
    mem_data_ok = 1'b1; mem_rdata = 32'h88888888;
    at_neg();
    chk("t6_stray_data_ok", {66'd0, inst_data_ok, data_data_ok, dbg_state}, 70'd0);
    next_cycle();
    mem_data_ok = 1'b0;
    at_neg();
    chk("t6_still_idle", {67'd0, mem_req, dbg_state}, 70'd0);
    chk("final_drained", {38'd0, exp_a_q.size()} + {38'd0, exp_d_q.size()}, 70'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
